// File: rtl/bus_scheduler.sv
// -----------------------------------------------------------------------------
// bus_scheduler
//
// Shares one Wishbone RAM peripheral between two controllers (controller 0 is
// the SPI bridge, controller 1 is the video fetch) and a 6502-style CPU that
// owns the bus for the tail of every 64-slot frame.
//
// A 6-bit slot counter runs at 64 MHz and produces the 1 MHz CPU clock
// (slot[5]). The CPU owns the bus from slot CPU_BE_FIRST to 63. Wishbone
// transfers may only start in slots 0..ISSUE_LAST. If a transfer is still
// outstanding when the counter reaches CPU_BE_FIRST-1, the counter stops
// there. This stretches the CPU clock low phase until the RAM is free.
//
// Parameters:
//   ISSUE_LAST    last slot in which a new transfer may be issued
//   CPU_BE_FIRST  first slot in which the CPU owns the bus
//
// Ports:
//   wb_clock_i      64 MHz clock
//   wb_reset_ni     asynchronous active-low reset
//   wbc0_*          controller 0 request (cycle/strobe in, stall/ack out)
//   wbc1_*          controller 1 request (cycle/strobe in, stall/ack out)
//   wbp_*           RAM peripheral (cycle/strobe out, stall/ack in)
//   grant_sel_o     controller that owns the current transfer (addr/data mux)
//   slot_o          slot counter
//   cpu_be_o        CPU bus enable (1 = CPU drives the bus)
//   cpu_clock_o     1 MHz CPU clock
//
// Configuration macro:
//   BUS_SCHEDULER_RR_EN  defined   -> round-robin between simultaneous requests
//                        undefined -> fixed priority, controller 0 first
// -----------------------------------------------------------------------------
module bus_scheduler #(
  parameter logic [5:0] ISSUE_LAST   = 6'd31,
  parameter logic [5:0] CPU_BE_FIRST = 6'd40
) (
  input  logic       wb_clock_i,
  input  logic       wb_reset_ni,
  input  logic       wbc0_cycle_i,
  input  logic       wbc0_strobe_i,
  output logic       wbc0_stall_o,
  output logic       wbc0_ack_o,
  input  logic       wbc1_cycle_i,
  input  logic       wbc1_strobe_i,
  output logic       wbc1_stall_o,
  output logic       wbc1_ack_o,
  output logic       wbp_cycle_o,
  output logic       wbp_strobe_o,
  input  logic       wbp_stall_i,
  input  logic       wbp_ack_i,
  output logic       grant_sel_o,
  output logic [5:0] slot_o,
  output logic       cpu_be_o,
  output logic       cpu_clock_o
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_ACK = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [5:0] r_slot;
  logic [5:0] w_slot_nxt;
  logic       r_grant_sel;
  logic       w_grant_nxt;
  logic       w_req0;
  logic       w_req1;
  logic       w_sel_cycle;
  logic       w_winner;

  assign w_req0 = wbc0_cycle_i & wbc0_strobe_i;
  assign w_req1 = wbc1_cycle_i & wbc1_strobe_i;

  // The granted controller may abandon its transfer by dropping cycle.
  assign w_sel_cycle = r_grant_sel ? wbc1_cycle_i : wbc0_cycle_i;

  // ---------------------------------------------------------------------------
  // Arbitration. w_winner is only consumed when at least one request is
  // present, so "not controller 0" means controller 1 is requesting.
  // ---------------------------------------------------------------------------
`ifdef BUS_SCHEDULER_RR_EN
  logic r_rr_ptr;
  logic w_grant_done;

  // The pointer names the controller with priority on a tie.
  assign w_winner     = (w_req0 & w_req1) ? r_rr_ptr : ~w_req0;
  assign w_grant_done = (r_state != ST_IDLE) && (w_state_nxt == ST_IDLE);

  always_ff @(posedge wb_clock_i or negedge wb_reset_ni) begin
    if (!wb_reset_ni) begin
      r_rr_ptr <= 1'b0;
    end else if (w_grant_done) begin
      // Hand priority to whichever controller did not just own the bus,
      // whether its grant completed or was aborted.
      r_rr_ptr <= ~r_grant_sel;
    end
  end
`else
  assign w_winner = ~w_req0;
`endif

  // ---------------------------------------------------------------------------
  // Slot counter. It stops at CPU_BE_FIRST-1 while a transfer is outstanding,
  // so the CPU never takes a bus that is still in use. Since transfers only
  // start at or before ISSUE_LAST, the counter can only meet a busy FSM on
  // its way up to that hold point.
  // ---------------------------------------------------------------------------
  assign w_slot_nxt = ((r_state != ST_IDLE) && (r_slot == CPU_BE_FIRST - 6'd1))
                      ? r_slot : r_slot + 6'd1;

  // NOTE: every register sits in an always_ff with an async reset branch and
  // uses non-blocking assignments, so all flops update together at the edge
  // and the reset values appear as soon as wb_reset_ni falls.
  always_ff @(posedge wb_clock_i or negedge wb_reset_ni) begin
    if (!wb_reset_ni) begin
      r_slot      <= 6'd0;
      r_state     <= ST_IDLE;
      r_grant_sel <= 1'b0;
    end else begin
      r_slot      <= w_slot_nxt;
      r_state     <= w_state_nxt;
      r_grant_sel <= w_grant_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and Wishbone outputs.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block is given a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant_sel;
    wbp_cycle_o  = 1'b0;
    wbp_strobe_o = 1'b0;
    wbc0_stall_o = 1'b1;
    wbc1_stall_o = 1'b1;
    wbc0_ack_o   = 1'b0;
    wbc1_ack_o   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if ((r_slot <= ISSUE_LAST) && (w_req0 | w_req1)) begin
          w_state_nxt = ST_REQ;
          w_grant_nxt = w_winner;
        end
      end

      ST_REQ: begin
        wbp_cycle_o  = 1'b1;
        wbp_strobe_o = 1'b1;
        // The peripheral's stall passes straight through to the owner, so
        // the owner sees its request accepted in the same cycle as the RAM.
        if (r_grant_sel) wbc1_stall_o = wbp_stall_i;
        else             wbc0_stall_o = wbp_stall_i;
        if (!w_sel_cycle)      w_state_nxt = ST_IDLE;
        else if (!wbp_stall_i) w_state_nxt = ST_WAIT_ACK;
      end

      ST_WAIT_ACK: begin
        wbp_cycle_o = 1'b1;
        if (r_grant_sel) wbc1_ack_o = wbp_ack_i;
        else             wbc0_ack_o = wbp_ack_i;
        if (!w_sel_cycle || wbp_ack_i) w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Counter decodes: straight from the register, no added latency.
  // ---------------------------------------------------------------------------
  assign slot_o      = r_slot;
  assign grant_sel_o = r_grant_sel;
  assign cpu_be_o    = (r_slot >= CPU_BE_FIRST);
  assign cpu_clock_o = r_slot[5];

endmodule

// File: doc/bus_scheduler.md
BUS_SCHEDULER -- requirements
Module: bus_scheduler

Interface
REQ-001 Parameter ISSUE_LAST, default 6'd31: last slot value in which a new Wishbone transfer may be issued.
REQ-002 Parameter CPU_BE_FIRST, default 6'd40: first slot value in which the CPU owns the bus.
REQ-003 wb_clock_i  in  1  64 MHz clock; the only clock.
REQ-004 wb_reset_ni  in  1  asynchronous, active-low reset.
REQ-005 wbc0_cycle_i, wbc0_strobe_i  in  1 each  controller 0 (SPI bridge) request.
REQ-006 wbc0_stall_o, wbc0_ack_o  out  1 each  controller 0 stall and ack.
REQ-007 wbc1_cycle_i, wbc1_strobe_i  in  1 each  controller 1 (video fetch) request.
REQ-008 wbc1_stall_o, wbc1_ack_o  out  1 each  controller 1 stall and ack.
REQ-009 wbp_cycle_o, wbp_strobe_o  out  1 each  request to the shared RAM peripheral.
REQ-010 wbp_stall_i, wbp_ack_i  in  1 each  RAM peripheral stall and ack.
REQ-011 grant_sel_o  out  1  selected controller, used by the top level for the addr/data/we mux.
REQ-012 slot_o  out  6  current slot counter.
REQ-013 cpu_be_o  out  1  CPU bus enable; 1 = CPU drives bus.
REQ-014 cpu_clock_o  out  1  1 MHz CPU clock.

Function
REQ-015 The slot counter SHALL increment by 1 each clock and wrap 63->0, except as stated in REQ-016.
REQ-016 The counter SHALL hold at CPU_BE_FIRST-1 while state != IDLE, and resume on the cycle after state returns to IDLE. This stretch prevents the CPU from taking a bus that is in use.
REQ-017 cpu_be_o SHALL be 1 if and only if slot_o >= CPU_BE_FIRST. cpu_clock_o SHALL equal slot_o[5]. Both are decoded from the counter register with no added latency.
REQ-018 FSM states: IDLE, REQ, WAIT_ACK. Exactly one transfer is outstanding at a time.
REQ-019 IDLE->REQ SHALL occur when slot_o <= ISSUE_LAST and at least one controller has cycle&strobe asserted. The winner SHALL be latched into grant_sel_o on the same edge.
REQ-020 In REQ: wbp_cycle_o=1 and wbp_strobe_o=1. When wbp_stall_i=0, the selected controller's stall_o SHALL be 0 for that cycle, and the FSM SHALL go to WAIT_ACK.
REQ-021 In WAIT_ACK: wbp_cycle_o=1 and wbp_strobe_o=0. The selected controller's ack_o SHALL equal wbp_ack_i combinationally. When wbp_ack_i=1, the FSM SHALL go to IDLE.
REQ-022 The non-selected controller SHALL see stall_o=1 and ack_o=0 at all times. In IDLE, both stall_o=1.
REQ-023 Abort: if the selected controller drops cycle_i in REQ or WAIT_ACK, the FSM SHALL go to IDLE on the next edge, with no ack and wbp_cycle_o=0.
REQ-024 If a request arrives with slot_o > ISSUE_LAST, it SHALL wait, stalled, until the slot wraps to 0.
REQ-025 grant_sel_o SHALL stay stable from IDLE->REQ until the FSM returns to IDLE.

Reset
REQ-026 While wb_reset_ni=0, the following SHALL hold immediately (asynchronously):
- slot=0, state=IDLE, grant_sel_o=0, round-robin pointer=0
- cpu_be_o=0, cpu_clock_o=0
- wbp_cycle_o=0, wbp_strobe_o=0
- both stall_o=1, both ack_o=0
REQ-027 Reset asserted mid-transfer SHALL abandon the transfer. A late wbp_ack_i after reset SHALL be ignored.

Configuration
REQ-028 With BUS_SCHEDULER_RR_EN defined, simultaneous requests SHALL be arbitrated round-robin. The pointer toggles after each completed or aborted grant, and the controller not last granted wins.
REQ-029 Without BUS_SCHEDULER_RR_EN, arbitration SHALL be fixed priority with controller 0 over controller 1, and no pointer register SHALL exist.

Verification
REQ-030 Release reset, no requests -> slot_o counts 0..63 and wraps; cpu_be_o=1 for slots 40..63; cpu_clock_o=1 for slots 32..63.
REQ-031 c0 requests at slot 5, wbp_stall_i=0, ack 3 clocks later -> REQ at slot 6, wbc0_stall_o=0 at slot 6, wbc0_ack_o pulses once, grant_sel_o=0.
REQ-032 c1 requests at slot 35 -> held stalled, issued at slot 0 of the next frame, no wbp_cycle_o in slots 32..63.
REQ-033 c0 issued at slot 31, ack withheld until 20 clocks later -> slot_o holds at 39, cpu_be_o stays 0, counting resumes after ack.
REQ-034 c0 and c1 request continuously: RR_EN defined -> grants alternate 0,1,0,1; undefined -> all grants go to 0.
REQ-035 Two aborts: c0 drops cycle in WAIT_ACK -> IDLE next clock, no ack. Reset asserted in WAIT_ACK -> all outputs at reset values immediately.
